// File: rtl/mbi5153_fb_writer.sv
// Raster pixel stream to triple-section, double-buffered pixel memory writer.
// Swaps banks and requests a frame send once a full frame has been written.
module mbi5153_fb_writer #(
   parameter int IMG_WIDTH_MAX      = 64,
   parameter int IMG_WIDTH_MAX_LOG2 = $clog2(IMG_WIDTH_MAX + 1),
   parameter int NUMBER_OF_LANES    = 3,
   parameter int MEM_ADDR_WIDTH     = $clog2(IMG_WIDTH_MAX * 32)
) (
   input  logic                          CLK,
   input  logic                          RESET,
   input  logic [IMG_WIDTH_MAX_LOG2-1:0] IMG_WIDTH,
   input  logic [4:0]                    SCAN_RATIO,
   input  logic                          PIX_VALID,
   input  logic [23:0]                   PIX_DATA,
   input  logic                          PIX_SOF,
   input  logic                          PIX_EOL,
   output logic                          PIX_READY,
   input  logic                          FRAME_TX_ACTIVE,
   output logic [NUMBER_OF_LANES-1:0]    WR_EN,
   output logic [MEM_ADDR_WIDTH:0]       WR_ADDR,
   output logic [23:0]                   WR_DATA,
   output logic                          BANK_FRONT,
   output logic                          VSYNC_STB,
   output logic                          ERR_LINE,
   output logic                          ERR_FRAME
);

   localparam int XW = IMG_WIDTH_MAX_LOG2;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SWAP} state_t;

   state_t                       r_state;
   logic [XW-1:0]                r_w;
   logic [5:0]                   r_l;
   logic [XW-1:0]                r_x;
   logic [4:0]                   r_row;
   logic [1:0]                   r_sec;
   logic                         r_ready;
   logic [NUMBER_OF_LANES-1:0]   r_wr_en;
   logic [MEM_ADDR_WIDTH:0]      r_wr_addr;
   logic [23:0]                  r_wr_data;
   logic                         r_bank_front;
   logic                         r_vsync;
   logic                         r_err_line;
   logic                         r_err_frame;

   logic                         w_accept;
   logic                         w_sof;
   logic                         w_beat;
   logic                         w_zero_w;
   logic [XW-1:0]                w_cur_w;
   logic [5:0]                   w_cur_l;
   logic [XW-1:0]                w_cur_x;
   logic [4:0]                   w_cur_row;
   logic [1:0]                   w_cur_sec;
   logic                         w_in_range;
   logic                         w_short;
   logic                         w_row_last;
   logic                         w_sec_last;
   logic [MEM_ADDR_WIDTH-1:0]    w_addr;
   logic [NUMBER_OF_LANES-1:0]   w_lane_hot;

   // An accepted SOF restarts addressing, so every beat works on these
   // "current" values rather than the raw registers.
   assign w_accept   = PIX_VALID & r_ready;
   assign w_sof      = w_accept & PIX_SOF;
   assign w_beat     = w_accept & (PIX_SOF | (r_state == S_LOAD));
   assign w_zero_w   = (IMG_WIDTH == '0);
   assign w_cur_w    = w_sof ? IMG_WIDTH : r_w;
   assign w_cur_l    = w_sof ? ({1'b0, SCAN_RATIO} + 6'd1) : r_l;
   assign w_cur_x    = w_sof ? '0 : r_x;
   assign w_cur_row  = w_sof ? '0 : r_row;
   assign w_cur_sec  = w_sof ? '0 : r_sec;
   assign w_in_range = (w_cur_x < w_cur_w);
   assign w_short    = PIX_EOL & (({1'b0, w_cur_x} + (XW+1)'(1)) < {1'b0, w_cur_w});
   assign w_row_last = (({1'b0, w_cur_row} + 6'd1) == w_cur_l);
   assign w_sec_last = (w_cur_sec == 2'(NUMBER_OF_LANES - 1));
   assign w_addr     = MEM_ADDR_WIDTH'(w_cur_row) * MEM_ADDR_WIDTH'(IMG_WIDTH_MAX)
                     + MEM_ADDR_WIDTH'(w_cur_x);
   assign w_lane_hot = NUMBER_OF_LANES'(1) << w_cur_sec;

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         r_state      <= S_IDLE;
         r_w          <= '0;
         r_l          <= '0;
         r_x          <= '0;
         r_row        <= '0;
         r_sec        <= '0;
         r_ready      <= 1'b1;
         r_wr_en      <= '0;
         r_wr_addr    <= '0;
         r_wr_data    <= '0;
         r_bank_front <= 1'b0;
         r_vsync      <= 1'b0;
         r_err_line   <= 1'b0;
         r_err_frame  <= 1'b0;
      end else begin
         // NOTE: these are defaults; a later non-blocking assignment to the
         // same register in this block overrides them for this cycle.
         r_wr_en <= '0;
         r_vsync <= 1'b0;
         case (r_state)
            S_IDLE, S_LOAD: begin
               if (w_beat) begin
                  if (w_sof) begin
                     r_w <= IMG_WIDTH;
                     r_l <= w_cur_l;
                     if (r_state == S_LOAD) r_err_frame <= 1'b1;
                  end
                  if (w_sof && w_zero_w) begin
                     r_err_line <= 1'b1;
                     r_state    <= S_IDLE;
                  end else begin
                     r_state    <= S_LOAD;
                     r_x        <= w_cur_x;
                     r_row      <= w_cur_row;
                     r_sec      <= w_cur_sec;
                     r_err_line <= (r_err_line & ~w_sof) | ~w_in_range | w_short;
                     if (w_in_range) begin
                        r_wr_en   <= w_lane_hot;
                        r_wr_addr <= {~r_bank_front, w_addr};
                        r_wr_data <= PIX_DATA;
                     end
                     if (PIX_EOL) begin
                        r_x <= '0;
                        if (w_row_last) begin
                           r_row <= '0;
                           if (w_sec_last) begin
                              r_state <= S_SWAP;
                              r_ready <= 1'b0;
                           end else begin
                              r_sec <= w_cur_sec + 2'd1;
                           end
                        end else begin
                           r_row <= w_cur_row + 5'd1;
                        end
                     end else if (w_in_range) begin
                        r_x <= w_cur_x + XW'(1);
                     end
                  end
               end
            end
            S_SWAP: begin
               if (!FRAME_TX_ACTIVE) begin
                  r_bank_front <= ~r_bank_front;
                  r_vsync      <= 1'b1;
                  r_ready      <= 1'b1;
                  r_state      <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign PIX_READY  = r_ready;
   assign WR_EN      = r_wr_en;
   assign WR_ADDR    = r_wr_addr;
   assign WR_DATA    = r_wr_data;
   assign BANK_FRONT = r_bank_front;
   assign VSYNC_STB  = r_vsync;
   assign ERR_LINE   = r_err_line;
   assign ERR_FRAME  = r_err_frame;

endmodule

// File: doc/mbi5153_fb_writer.md
Name: mbi5153_fb_writer

Overview:
- Upstream feeder of the MBI5153 display top: takes a raster pixel stream (24-bit RGB, SOF/EOL-framed) and writes it into the three parallel pixel memories (TOP/MID/BOT row sections) that the display side reads via MEM_ADDR.
- Double-buffered: writes the back bank while the front bank is displayed.
- On a complete frame, swaps banks when the display side is idle and issues the VSYNC_STB frame-send request.

Parameters:
- IMG_WIDTH_MAX, 64, maximum pixels per line.
- IMG_WIDTH_MAX_LOG2, $clog2(IMG_WIDTH_MAX+1), width of the IMG_WIDTH bus.
- NUMBER_OF_LANES, 3, number of row sections/memories in use (1..3).
- MEM_ADDR_WIDTH, $clog2(IMG_WIDTH_MAX*32), per-bank address width.

Ports:
- CLK  in  1  single system clock (same clock as the display DCLK_IN domain).
- RESET  in  1  synchronous, active-low reset.
- IMG_WIDTH  in  IMG_WIDTH_MAX_LOG2  active line width, 1..IMG_WIDTH_MAX; sampled at SOF.
- SCAN_RATIO  in  5  lines per section minus 1 (0 = 1 line, 31 = 32 lines); sampled at SOF.
- PIX_VALID  in  1  stream pixel valid.
- PIX_DATA  in  24  RGB pixel, R[23:16] G[15:8] B[7:0].
- PIX_SOF  in  1  marks the first pixel of a frame; qualified by PIX_VALID.
- PIX_EOL  in  1  marks the last pixel of a line; qualified by PIX_VALID.
- PIX_READY  out  1  stream accept; a beat transfers when PIX_VALID & PIX_READY.
- FRAME_TX_ACTIVE  in  1  display side is currently reading the front bank.
- WR_EN  out  NUMBER_OF_LANES  one-hot write strobe, bit k = memory k (0 = TOP).
- WR_ADDR  out  MEM_ADDR_WIDTH+1  {bank, row*IMG_WIDTH_MAX + x}.
- WR_DATA  out  24  pixel data to write.
- BANK_FRONT  out  1  bank the display side reads; drives the read address MSB.
- VSYNC_STB  out  1  one-cycle frame-send request.
- ERR_LINE  out  1  sticky: a short line or an overlong line was seen; cleared at the next accepted SOF.
- ERR_FRAME  out  1  sticky: SOF arrived mid-frame; cleared by reset only.

Behaviour:
- Reset (RESET=0 at a CLK edge):
  - State goes to IDLE.
  - All outputs are 0 except PIX_READY=1.
  - BANK_FRONT=0, so writes target bank 1.
  - Counters are cleared.
  - Reset mid-frame abandons the frame with no VSYNC_STB.
- State IDLE:
  - PIX_READY=1.
  - Beats without SOF are discarded with no write.
  - An accepted SOF beat does the following:
    - latches W=IMG_WIDTH and L=SCAN_RATIO+1;
    - sets x=0, row=0, sec=0;
    - writes the beat;
    - goes to LOAD.
  - If IMG_WIDTH==0 at SOF, the frame is ignored (stays in IDLE) and ERR_LINE is set.
- State LOAD, for each accepted beat:
  - If x < W, write the pixel:
    - WR_EN[sec]=1;
    - WR_ADDR = {~BANK_FRONT, row*IMG_WIDTH_MAX + x};
    - WR_DATA = PIX_DATA.
  - If x >= W, drop the beat and set ERR_LINE.
  - Write latency is exactly 1 cycle after acceptance (registered outputs). WR_EN is 0 in cycles with no accepted beat.
  - On EOL:
    - if x+1 < W, set ERR_LINE (short line); the remaining pixels are not written and keep their stale contents;
    - then x=0 and row=row+1;
    - if row+1==L: row=0, sec=sec+1.
  - Without EOL, x=x+1, saturating at W.
  - SOF accepted in LOAD: set ERR_FRAME, restart the frame (x, row, sec = 0, re-latch W and L) and write the beat.
  - When the EOL of row L-1 of section NUMBER_OF_LANES-1 is accepted, go to SWAP.
- State SWAP:
  - PIX_READY=0.
  - If FRAME_TX_ACTIVE=0 in the current cycle:
    - toggle BANK_FRONT;
    - pulse VSYNC_STB for 1 cycle;
    - go to IDLE.
    - The swap occurs no earlier than the cycle after the last write.
  - If FRAME_TX_ACTIVE=1, wait in SWAP indefinitely, holding back-pressure.
- Address arithmetic:
  - row*IMG_WIDTH_MAX + x is unsigned and fits MEM_ADDR_WIDTH, because row < 32 and x < IMG_WIDTH_MAX.
  - No wrap-around: x saturates and sec never exceeds NUMBER_OF_LANES-1.
- Simultaneous SOF and EOL on one beat:
  - the beat is a one-pixel line;
  - SOF handling applies first, then EOL.
- VSYNC_STB and BANK_FRONT change in the same cycle.
- The display side must only use the new front bank after VSYNC_STB.

Test Plan:
- Reset with RESET=0 for 2 cycles -> PIX_READY=1, WR_EN=0, BANK_FRONT=0, VSYNC_STB=0, ERR_* = 0.
- W=4, SCAN_RATIO=1, 3 lanes, 24 beats with EOL every 4th, FRAME_TX_ACTIVE=0:
  - pixel (x=2, y=3) is written with WR_EN=3'b010 and WR_ADDR={1, 1*64+2}=66+64*32 (bank 1);
  - after the last write, BANK_FRONT=1 and VSYNC_STB is a single pulse.
- Same frame with FRAME_TX_ACTIVE=1 held for 10 cycles after the last beat -> PIX_READY=0 for 10 cycles, no VSYNC_STB; the swap and pulse occur in the cycle FRAME_TX_ACTIVE falls.
- W=4, a line with EOL on its 2nd pixel -> ERR_LINE=1; the next line starts at x=0 on the following row; the frame still completes.
- W=4, a line of 6 beats with EOL on the 6th -> beats 5 and 6 are not written (WR_EN=0), ERR_LINE=1.
- SOF injected on row 2 of the frame -> ERR_FRAME=1, addressing restarts at row 0/sec 0 of the same back bank, no VSYNC_STB until the restarted frame completes.
